// File: rtl/pio_in_port.sv
// pio_in_port: synchronised, debounced parallel input port
// with sticky W1C edge flags and a maskable level irq.
//
// Ports:
//   clk    system clock, rising edge
//   reset  async active-low reset
//   PORTI  raw external inputs (async)
//   cs/wen bus select / write enable
//   addr   0 deb, 1 rise, 2 fall, 3 mask
//   wdata  write data
//   rdata  read data (comb. from addr)
//   irq    OR of unmasked flags, registered
module pio_in_port #(
  parameter int WIDTH = 32,
  parameter int DIV   = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PORTI,
  input  logic             cs,
  input  logic             wen,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  localparam int CW =
    (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DIV - 1);

  logic [CW-1:0]    cnt;
  logic             tick;

  logic [WIDTH-1:0] sync_a;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] deb;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] mask;

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] rise_set;
  logic [WIDTH-1:0] fall_set;
  logic [WIDTH-1:0] rise_clr;
  logic [WIDTH-1:0] fall_clr;

  logic             wr;
  logic             wr_rise;
  logic             wr_fall;
  logic             wr_mask;

  // prescaler
  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // two-flop synchroniser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync   <= '0;
    end else begin
      sync_a <= PORTI;
      sync   <= sync_a;
    end
  end

  // current sample agrees with the two
  // previous tick samples
  assign stable = ~(sync ^ s0) & ~(s0 ^ s1);
  assign flip   = tick
                ? (stable & (sync ^ deb))
                : '0;

  assign rise_set = flip & sync;
  assign fall_set = flip & ~sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0  <= '0;
      s1  <= '0;
      deb <= '0;
    end else if (tick) begin
      s1  <= s0;
      s0  <= sync;
      deb <= deb ^ flip;
    end
  end

  // bus write decode
  assign wr = cs & wen;

  always_comb begin
    wr_rise = 1'b0;
    wr_fall = 1'b0;
    wr_mask = 1'b0;
    unique case (1'b1)
      (addr == 2'd1): wr_rise = wr;
      (addr == 2'd2): wr_fall = wr;
      (addr == 2'd3): wr_mask = wr;
      default: ;
    endcase
  end

  assign rise_clr = wr_rise ? wdata : '0;
  assign fall_clr = wr_fall ? wdata : '0;

  // set is applied after clear so a
  // coincident edge is never lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= (rise & ~rise_clr) | rise_set;
      fall <= (fall & ~fall_clr) | fall_set;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask <= '0;
    end else if (wr_mask) begin
      mask <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |((rise | fall) & mask);
    end
  end

  // read mux
  always_comb begin
    rdata = '0;
    unique case (addr)
      2'd0: rdata = deb;
      2'd1: rdata = rise;
      2'd2: rdata = fall;
      2'd3: rdata = mask;
      default: rdata = '0;
    endcase
  end

endmodule
